// File: rtl/var_table_pkg.sv
// Shared types for the BCP variable table controller.
// Opcodes, status codes, value encoding and FSM states.
package var_table_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_ASSIGN = 2'b10
  } op_e;

  typedef enum logic [1:0] {
    STS_OK       = 2'b00,
    STS_ALREADY  = 2'b01,
    STS_CONFLICT = 2'b10,
    STS_TIMEOUT  = 2'b11
  } status_e;

  localparam logic [1:0] VAL_UNASSIGNED = 2'b00;
  localparam logic [1:0] VAL_FALSE      = 2'b01;
  localparam logic [1:0] VAL_TRUE       = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_DECIDE   = 3'd3,
    S_WR_ISSUE = 3'd4,
    S_WR_WAIT  = 3'd5,
    S_RESP     = 3'd6
  } state_e;

  // Reserved opcode 11 falls back to READ.
  function automatic op_e decode_op(
    input logic [1:0] raw
  );
    unique case (raw)
      2'b01:   return OP_WRITE;
      2'b10:   return OP_ASSIGN;
      default: return OP_READ;
    endcase
  endfunction

endpackage

// File: rtl/var_assign_decide.sv
// Test-and-set decision for ASSIGN: compares the stored
// 2-bit value with the request and builds the merged word.
module var_assign_decide
  import var_table_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_req,
  output logic              o_write,
  output status_e           o_status,
  output logic [DATA_W-1:0] o_wword
);

  logic w_req_ok;
  logic w_unset;
  logic w_skip;
  logic w_fill;
  logic w_same;
  logic w_opp;

  assign w_req_ok = (i_req == VAL_FALSE) ||
                    (i_req == VAL_TRUE);
  // Illegal stored 11 counts as unassigned.
  assign w_unset  = (i_word[1:0] == VAL_UNASSIGNED) ||
                    (i_word[1:0] == 2'b11);

  assign w_skip = !w_req_ok;
  assign w_fill = w_req_ok && w_unset;
  assign w_same = w_req_ok && !w_unset &&
                  (i_word[1:0] == i_req);
  assign w_opp  = w_req_ok && !w_unset &&
                  (i_word[1:0] != i_req);

  assign o_wword = {i_word[DATA_W-1:2], i_req};

  always_comb begin
    o_write  = 1'b0;
    o_status = STS_OK;
    unique case (1'b1)
      w_skip: o_status = STS_OK;
      w_fill: o_write  = 1'b1;
      w_same: o_status = STS_ALREADY;
      w_opp:  o_status = STS_CONFLICT;
      default: o_status = STS_OK;
    endcase
  end

endmodule

// File: rtl/var_table_ctrl.sv
// Requester-side controller for the BCP variable table:
// sequences READ/WRITE/ASSIGN accesses and returns status.
module var_table_ctrl
  import var_table_pkg::*;
#(
  parameter int DATA_W  = 9,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              tbl_enable,
  output logic              tbl_rd,
  output logic              tbl_wr,
  output logic [ADDR_W-1:0] tbl_addr,
  output logic [DATA_W-1:0] tbl_wdata,
  input  logic [DATA_W-1:0] tbl_rdata,
  input  logic              tbl_work
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            r_state;
  op_e               r_op;
  status_e           r_status;
  logic              r_cmd_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_data;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_expired;
  op_e               w_op;
  logic              w_write;
  status_e           w_status;
  logic [DATA_W-1:0] w_wword;

  assign w_op      = decode_op(cmd_op);
  assign w_accept  = cmd_valid && r_cmd_ready;
  assign w_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

  // r_wdata[1:0] still holds the requested value in DECIDE.
  var_assign_decide #(
    .DATA_W (DATA_W)
  ) u_decide (
    .i_word   (r_rsp_data),
    .i_req    (r_wdata[1:0]),
    .o_write  (w_write),
    .o_status (w_status),
    .o_wword  (w_wword)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_READ;
      r_status    <= STS_OK;
      r_cmd_ready <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_data  <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_op        <= w_op;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_data;
            r_rsp_data  <= '0;
            r_status    <= STS_OK;
            r_state     <= (w_op == OP_WRITE) ?
                           S_WR_ISSUE : S_RD_ISSUE;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_RD_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (tbl_work) begin
            r_rsp_data <= tbl_rdata;
            r_state    <= S_DECIDE;
          end else if (w_expired) begin
            r_rsp_data <= '0;
            r_status   <= STS_TIMEOUT;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DECIDE: begin
          if (r_op == OP_ASSIGN && w_write) begin
            r_wdata <= w_wword;
            r_state <= S_WR_ISSUE;
          end else begin
            r_status <= (r_op == OP_ASSIGN) ?
                        w_status : STS_OK;
            r_state  <= S_RESP;
          end
        end
        S_WR_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (tbl_work) begin
            r_status <= STS_OK;
            r_state  <= S_RESP;
          end else if (w_expired) begin
            r_rsp_data <= '0;
            r_status   <= STS_TIMEOUT;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_status;
  assign tbl_rd     = (r_state == S_RD_ISSUE);
  assign tbl_wr     = (r_state == S_WR_ISSUE);
  assign tbl_enable = tbl_rd || tbl_wr;
  assign tbl_addr   = r_addr;
  assign tbl_wdata  = r_wdata;

endmodule

// File: tb/tb_var_table_ctrl.sv
// Directed bench for var_table_ctrl with a small table
// responder model and per-scenario inline checks.
module tb_var_table_ctrl;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_addr;
  logic [8:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [8:0] rsp_data;
  logic [1:0] rsp_status;
  logic       tbl_enable;
  logic       tbl_rd;
  logic       tbl_wr;
  logic [2:0] tbl_addr;
  logic [8:0] tbl_wdata;
  logic [8:0] tbl_rdata;
  logic       tbl_work;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_en = 0;
  int n_rd = 0;
  int n_wr = 0;
  int consec = 0;
  int both = 0;
  logic [2:0] last_waddr = '0;
  logic [8:0] last_wdata = '0;
  logic       ack_en;
  logic       inj_work;
  logic       pend = 1'b0;
  logic       prev_en = 1'b0;
  logic [2:0] pend_addr = '0;
  logic [8:0] mem [8];

  var_table_ctrl #(
    .DATA_W  (9),
    .ADDR_W  (3),
    .TIMEOUT (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_status (rsp_status),
    .tbl_enable (tbl_enable),
    .tbl_rd     (tbl_rd),
    .tbl_wr     (tbl_wr),
    .tbl_addr   (tbl_addr),
    .tbl_wdata  (tbl_wdata),
    .tbl_rdata  (tbl_rdata),
    .tbl_work   (tbl_work)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Table model: acks one cycle after each strobe.
  initial begin
    tbl_work  = 1'b0;
    tbl_rdata = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem[0] = 9'h100;
    mem[1] = 9'h0FF;
    mem[3] = 9'h0A3;
    mem[4] = 9'h055;
    forever begin
      @(posedge clock);
      cyc++;
      #2;
      tbl_work  = (pend && reset) || inj_work;
      tbl_rdata = pend ? mem[pend_addr] : '0;
      pend      = 1'b0;
      @(negedge clock);
      if (tbl_enable) begin
        n_en++;
        if (prev_en) consec++;
        if (tbl_rd && tbl_wr) both++;
        if (tbl_rd) n_rd++;
        if (tbl_wr) begin
          n_wr++;
          last_waddr = tbl_addr;
          last_wdata = tbl_wdata;
          mem[tbl_addr] = tbl_wdata;
        end
        if (ack_en) begin
          pend      = 1'b1;
          pend_addr = tbl_addr;
        end
      end
      prev_en = tbl_enable;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] op,
                      input logic [2:0] a,
                      input logic [8:0] d,
                      output int acc,
                      output bit ok);
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (cmd_ready) begin
        acc = cyc;
        ok  = 1'b1;
        break;
      end
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget,
                          output int c,
                          output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (rsp_valid) begin
        c  = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int acc;
    bit ok;
    bit bad;
    logic [30:0] outs;
    repeat (2) @(negedge clock);
    outs = {cmd_ready, rsp_valid, rsp_data, rsp_status,
            tbl_enable, tbl_rd, tbl_wr, tbl_addr, tbl_wdata};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL rst_init got %h exp 0", outs);
    end
    tick();
    reset  = 1'b1;
    ack_en = 1'b0;
    send(2'b00, 3'd1, 9'h000, acc, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_accept got 0 exp 1");
    end
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    outs = {cmd_ready, rsp_valid, rsp_data, rsp_status,
            tbl_enable, tbl_rd, tbl_wr, tbl_addr, tbl_wdata};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL rst_mid got %h exp 0", outs);
    end
    tick();
    reset    = 1'b1;
    inj_work = 1'b1;
    tick();
    inj_work = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (rsp_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_no_rsp got 1 exp 0");
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b exp 1", cmd_ready);
    end
    ack_en = 1'b1;
    tick();
  endtask

  task automatic test_write();
    int acc, rc, b_wr, b_en;
    bit ok, ok2;
    b_wr = n_wr;
    b_en = n_en;
    send(2'b01, 3'd2, 9'h1A5, acc, ok);
    wait_rsp(20, rc, ok2);
    checks++;
    if (!(ok && ok2)) begin
      errors++;
      $display("FAIL wr_wait got %b%b exp 11", ok, ok2);
    end
    checks++;
    if (rc - acc != 3) begin
      errors++;
      $display("FAIL wr_lat got %0d exp 3", rc - acc);
    end
    checks++;
    if (rsp_status !== 2'b00 || rsp_data !== 9'h000) begin
      errors++;
      $display("FAIL wr_rsp got %h/%h exp 0/000",
               rsp_status, rsp_data);
    end
    checks++;
    if (n_wr - b_wr != 1 || n_en - b_en != 1) begin
      errors++;
      $display("FAIL wr_pulses got wr%0d en%0d exp 1 1",
               n_wr - b_wr, n_en - b_en);
    end
    checks++;
    if (last_waddr !== 3'd2 || last_wdata !== 9'h1A5) begin
      errors++;
      $display("FAIL wr_bus got %h/%h exp 2/1a5",
               last_waddr, last_wdata);
    end
    tick();
  endtask

  task automatic test_read();
    int acc, rc, b_rd;
    bit ok, ok2, bad;
    rsp_ready = 1'b0;
    b_rd = n_rd;
    send(2'b00, 3'd1, 9'h000, acc, ok);
    wait_rsp(20, rc, ok2);
    checks++;
    if (!(ok && ok2) || rc - acc != 4) begin
      errors++;
      $display("FAIL rd_lat got %0d exp 4", rc - acc);
    end
    checks++;
    if (rsp_status !== 2'b00 || rsp_data !== 9'h0FF) begin
      errors++;
      $display("FAIL rd_rsp got %h/%h exp 0/0ff",
               rsp_status, rsp_data);
    end
    checks++;
    if (n_rd - b_rd != 1) begin
      errors++;
      $display("FAIL rd_pulses got %0d exp 1", n_rd - b_rd);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (rsp_valid !== 1'b1 || rsp_data !== 9'h0FF ||
          rsp_status !== 2'b00 || cmd_ready !== 1'b0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rd_hold got unstable exp stable");
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_release got v%b r%b exp v0 r1",
               rsp_valid, cmd_ready);
    end
    tick();
    send(2'b11, 3'd1, 9'h000, acc, ok);
    wait_rsp(20, rc, ok2);
    checks++;
    if (!(ok && ok2) || rc - acc != 4 ||
        rsp_data !== 9'h0FF || rsp_status !== 2'b00) begin
      errors++;
      $display("FAIL rd_rsvd got %0d %h/%h exp 4 0/0ff",
               rc - acc, rsp_status, rsp_data);
    end
    tick();
  endtask

  task automatic test_assign();
    logic [2:0] t_addr [5];
    logic [8:0] t_req  [5];
    logic [8:0] t_data [5];
    logic [1:0] t_sts  [5];
    int         t_lat  [5];
    int         t_wr   [5];
    logic [8:0] t_wdat [5];
    int acc, rc, b_wr;
    bit ok, ok2;
    t_addr = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd3};
    t_req  = '{9'h002, 9'h002, 9'h001, 9'h003, 9'h001};
    t_data = '{9'h100, 9'h102, 9'h102, 9'h102, 9'h0A3};
    t_sts  = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    t_lat  = '{6, 4, 4, 4, 6};
    t_wr   = '{1, 0, 0, 0, 1};
    t_wdat = '{9'h102, 9'h000, 9'h000, 9'h000, 9'h0A1};
    for (int i = 0; i < 5; i++) begin
      b_wr = n_wr;
      send(2'b10, t_addr[i], t_req[i], acc, ok);
      wait_rsp(20, rc, ok2);
      checks++;
      if (!(ok && ok2) || rc - acc != t_lat[i]) begin
        errors++;
        $display("FAIL as%0d_lat got %0d exp %0d",
                 i, rc - acc, t_lat[i]);
      end
      checks++;
      if (rsp_data !== t_data[i] ||
          rsp_status !== t_sts[i]) begin
        errors++;
        $display("FAIL as%0d_rsp got %h/%h exp %h/%h", i,
                 rsp_status, rsp_data, t_sts[i], t_data[i]);
      end
      checks++;
      if (n_wr - b_wr != t_wr[i] ||
          (t_wr[i] == 1 && last_wdata !== t_wdat[i])) begin
        errors++;
        $display("FAIL as%0d_wr got %0d/%h exp %0d/%h", i,
                 n_wr - b_wr, last_wdata, t_wr[i], t_wdat[i]);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    int acc, rc;
    bit ok, ok2;
    ack_en    = 1'b0;
    rsp_ready = 1'b0;
    send(2'b00, 3'd4, 9'h000, acc, ok);
    wait_rsp(30, rc, ok2);
    checks++;
    if (!(ok && ok2) || rc - acc != 10) begin
      errors++;
      $display("FAIL to_lat got %0d exp 10", rc - acc);
    end
    checks++;
    if (rsp_status !== 2'b11 || rsp_data !== 9'h000) begin
      errors++;
      $display("FAIL to_rsp got %h/%h exp 3/000",
               rsp_status, rsp_data);
    end
    tick();
    inj_work = 1'b1;
    tick();
    inj_work = 1'b0;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== 2'b11 ||
        rsp_data !== 9'h000) begin
      errors++;
      $display("FAIL to_late got %b %h/%h exp 1 3/000",
               rsp_valid, rsp_status, rsp_data);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_done got %b exp 0", rsp_valid);
    end
    ack_en = 1'b1;
    tick();
    send(2'b00, 3'd4, 9'h000, acc, ok);
    wait_rsp(20, rc, ok2);
    checks++;
    if (!(ok && ok2) || rc - acc != 4 ||
        rsp_data !== 9'h055 || rsp_status !== 2'b00) begin
      errors++;
      $display("FAIL to_next got %0d %h/%h exp 4 0/055",
               rc - acc, rsp_status, rsp_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] b_op   [4];
    logic [2:0] b_addr [4];
    logic [8:0] b_wd   [4];
    logic [8:0] b_exp  [4];
    int acc [4];
    int hs  [4];
    int rc;
    bit ok, found;
    b_op   = '{2'b01, 2'b00, 2'b10, 2'b00};
    b_addr = '{3'd5, 3'd5, 3'd6, 3'd6};
    b_wd   = '{9'h033, 9'h000, 9'h002, 9'h000};
    b_exp  = '{9'h000, 9'h033, 9'h000, 9'h002};
    rsp_ready = 1'b1;
    cmd_op    = b_op[0];
    cmd_addr  = b_addr[0];
    cmd_data  = b_wd[0];
    cmd_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      found = 1'b0;
      acc[j] = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clock);
        if (cmd_ready) begin
          acc[j] = cyc;
          found  = 1'b1;
          break;
        end
      end
      tick();
      if (j < 3) begin
        cmd_op   = b_op[j+1];
        cmd_addr = b_addr[j+1];
        cmd_data = b_wd[j+1];
      end else begin
        cmd_valid = 1'b0;
      end
      wait_rsp(20, rc, ok);
      hs[j] = rc;
      checks++;
      if (!(found && ok) || rsp_data !== b_exp[j] ||
          rsp_status !== 2'b00) begin
        errors++;
        $display("FAIL b2b%0d_rsp got %h/%h exp 0/%h",
                 j, rsp_status, rsp_data, b_exp[j]);
      end
      if (j > 0) begin
        checks++;
        if (acc[j] != hs[j-1] + 1) begin
          errors++;
          $display("FAIL b2b%0d_gap got %0d exp %0d",
                   j, acc[j], hs[j-1] + 1);
        end
      end
    end
    tick();
    checks++;
    if (consec != 0 || both != 0) begin
      errors++;
      $display("FAIL tbl_strobe got c%0d b%0d exp 0 0",
               consec, both);
    end
  endtask

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    ack_en    = 1'b1;
    inj_work  = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_assign();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/var_table_ctrl.md
Name: var_table_ctrl

Overview:
Requester-side controller for the BCP variable table. It accepts READ, WRITE and ASSIGN (test-and-set) commands from the BCP engine over a valid/ready channel. It sequences single-cycle enable/read/write strobes to the table, waits for the table's work acknowledge, and returns a response with a status code. ASSIGN performs an atomic read-compare-write of a variable's 2-bit value and reports conflicts to the BCP engine.

Parameters:
DATA_W, 9, table word width
ADDR_W, 3, table address width
TIMEOUT, 8, max cycles to wait for tbl_work before aborting (>=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 READ, 01 WRITE, 10 ASSIGN, 11 reserved (treated as READ)
cmd_addr  in  ADDR_W  variable index
cmd_data  in  DATA_W  write word; ASSIGN uses bits [1:0] only
rsp_valid  out  1  response present
rsp_ready  in  1  engine accepts response
rsp_data  out  DATA_W  word read (READ/ASSIGN pre-value), 0 for WRITE
rsp_status  out  2  00 OK, 01 ALREADY, 10 CONFLICT, 11 TIMEOUT
tbl_enable  out  1  table access strobe
tbl_rd  out  1  read request, qualified by tbl_enable
tbl_wr  out  1  write request, qualified by tbl_enable
tbl_addr  out  ADDR_W  table address
tbl_wdata  out  DATA_W  table write data
tbl_rdata  in  DATA_W  table read data, valid when tbl_work=1 after a read
tbl_work  in  1  table acknowledge, one cycle per access

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0 except cmd_ready=0. Internal registers and timeout counter cleared. Reset mid-access abandons the access; no response is produced.
- Value encoding (bits [1:0]): 00 unassigned, 01 false, 10 true, 11 illegal (treated as unassigned).
- States: IDLE, RD_ISSUE, RD_WAIT, DECIDE, WR_ISSUE, WR_WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/addr/data. READ/ASSIGN go to RD_ISSUE; WRITE goes to WR_ISSUE.
- RD_ISSUE / WR_ISSUE: exactly one cycle with tbl_enable=1 and tbl_rd or tbl_wr=1 (never both). tbl_addr and tbl_wdata are driven from latched registers. Timeout counter is cleared.
- RD_WAIT / WR_WAIT: tbl_enable=0. Counter increments each cycle.
  - tbl_work=1 in RD_WAIT: capture tbl_rdata, go to DECIDE.
  - tbl_work=1 in WR_WAIT: go to RESP, status OK.
  - Counter reaches TIMEOUT: go to RESP, status TIMEOUT, rsp_data=0.
  - tbl_work seen in any other state is ignored.
- DECIDE (1 cycle):
  - READ: RESP/OK.
  - ASSIGN, stored value unassigned: WR_ISSUE with the captured word, bits [1:0] replaced by cmd bits [1:0].
  - ASSIGN, stored value equals request: RESP/ALREADY.
  - ASSIGN, stored value opposite: RESP/CONFLICT, no write.
  - ASSIGN with request 00 or 11: RESP/OK, no write.
- ASSIGN that writes returns rsp_data = pre-write captured word and status OK.
- RESP: rsp_valid=1 with data and status held stable until rsp_ready. The handshake cycle returns to IDLE. cmd_ready=0 throughout, so there is one command in flight at most.
- Latency with immediate table ack and rsp_ready=1:
  - READ: response 4 cycles after accept.
  - WRITE: response 3 cycles after accept.
  - Writing ASSIGN: response 6 cycles after accept.
- Back-to-back: the earliest next accept is the cycle after the response handshake. This guarantees at least one idle cycle on tbl_enable between accesses.

Decomposition:
- Package var_table_pkg holds:
  - op_e (READ/WRITE/ASSIGN)
  - status_e (OK/ALREADY/CONFLICT/TIMEOUT)
  - value encoding constants VAL_UNASSIGNED/VAL_FALSE/VAL_TRUE
  - state_e
- One sub-module, var_assign_decide: combinational compare of stored vs requested value, producing the write-needed flag, status and merged write word.
- FSM, counter and handshake registers live in the top module.

Test Plan:
- Reset while in RD_WAIT -> all outputs 0, state IDLE; no rsp_valid afterwards even if tbl_work pulses.
- WRITE addr 2, data 9'h1A5, table acks 1 cycle later -> single tbl_enable+tbl_wr pulse with tbl_addr=2, tbl_wdata=1A5; rsp_valid 3 cycles after accept, status 00, rsp_data 0.
- READ addr 1, table returns 9'h0FF -> single tbl_rd pulse; rsp_data=0FF, status OK; with rsp_ready held 0 for 3 cycles, the response holds stable and cmd_ready stays 0.
- ASSIGN addr 0 value 10, stored 9'h100 -> read then write of 9'h102; rsp_data=100, status OK. Repeat ASSIGN 10 -> ALREADY, no write. ASSIGN 01 -> CONFLICT, no tbl_wr pulse.
- READ with tbl_work never asserted, TIMEOUT=8 -> rsp status 11, rsp_data 0 after 8 wait cycles; a late tbl_work is ignored; the next command executes normally.
- Back-to-back stream of 4 commands with cmd_valid held high -> each accept exactly one cycle after the prior response handshake; tbl_enable is never high on consecutive cycles.
